// File: rtl/pipe_reg_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg_chain_pkg
// Purpose  : Shared constants and helpers for the pipe_reg_chain slice.
//            - STALL_CNT_W   : width of the optional stall counter
//            - DEFAULT_WIDTH : default data width reused by other slices
//            - DEFAULT_DEPTH : default stage count reused by other slices
//            - occ_width()   : width of an occupancy count for a given depth
// Revision : 1.0 - initial release
// ============================================================================
package pipe_reg_chain_pkg;

    localparam int STALL_CNT_W   = 16;
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Enough bits to count 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : pipe_reg_chain_pkg
`default_nettype wire

// File: rtl/pipe_reg_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg_stage
// Purpose  : One stage of the register chain: a valid bit plus a WIDTH-bit
//            data register with valid/ready flow control.
// Ports    : clk       - clock
//            reset     - synchronous active-high reset
//            flush     - synchronous clear of the valid bit
//            up_valid  - upstream stage (or producer) holds a word
//            up_data   - upstream word
//            dn_ready  - downstream stage can take this stage's word
//            rdy       - this stage can take a word this cycle
//            v         - this stage holds a valid word
//            d         - this stage's word
// Revision : 1.0 - initial release
// ============================================================================
module pipe_reg_stage
    import pipe_reg_chain_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             rdy,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    logic             r_v;
    logic [WIDTH-1:0] r_d;

    // Empty stages always accept, which is what collapses bubbles.
    assign rdy = ~r_v | dn_ready;
    assign v   = r_v;
    assign d   = r_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v <= 1'b0;
            r_d <= RESET_VAL;
        end else if (flush) begin
            // Data is left untouched so out_data keeps its last value.
            r_v <= 1'b0;
        end else if (rdy) begin
            r_v <= up_valid;
            // No data toggling when a bubble passes through.
            if (up_valid) begin
                r_d <= up_data;
            end
        end
    end

endmodule : pipe_reg_stage
`default_nettype wire

// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg_chain
// Purpose  : DEPTH-stage WIDTH-bit register chain with valid/ready flow
//            control, bubble collapsing and synchronous flush. Used as a
//            timing/retiming slice between producer and consumer.
// Ports    : clk, reset (sync, active-high), flush
//            in_valid / in_ready / in_data     - producer side
//            out_valid / out_ready / out_data  - consumer side
//            occupancy                         - registered valid-stage count
//            stall_cnt (16b, optional)         - saturating stall counter
// Config   : PIPE_REG_CHAIN_STALL_CNT_EN - when defined, adds stall_cnt,
//            counting cycles with out_valid & !out_ready; cleared only by
//            reset; saturates at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [occ_width(DEPTH)-1:0] occupancy
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0]      stall_cnt
`endif
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] w_v;
    logic [WIDTH-1:0] w_d [DEPTH];
    logic             w_in_fire;
    logic             w_out_fire;
    logic [OCC_W-1:0] r_occ;

    // Each stage keeps its own ready wire inside its generate scope so the
    // ready chain is a chain of distinct nets rather than one self-referencing
    // vector.
    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        logic             w_rdy;
        logic             w_dn_ready;
        logic             w_up_valid;
        logic [WIDTH-1:0] w_up_data;

        if (s == 0) begin : g_head
            assign w_up_valid = in_valid & ~flush;
            assign w_up_data  = in_data;
        end else begin : g_body
            assign w_up_valid = w_v[s-1];
            assign w_up_data  = w_d[s-1];
        end

        if (s == DEPTH - 1) begin : g_tail
            assign w_dn_ready = out_ready;
        end else begin : g_inner
            assign w_dn_ready = g_stage[s+1].w_rdy;
        end

        pipe_reg_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .up_valid (w_up_valid),
            .up_data  (w_up_data),
            .dn_ready (w_dn_ready),
            .rdy      (w_rdy),
            .v        (w_v[s]),
            .d        (w_d[s])
        );
    end

    // Flush blocks acceptance so no word is taken and then silently dropped.
    assign in_ready   = g_stage[0].w_rdy & ~flush;
    assign out_valid  = w_v[DEPTH-1];
    assign out_data   = w_d[DEPTH-1];
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign occupancy  = r_occ;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_occ <= '0;
        end else begin
            case ({w_in_fire, w_out_fire})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule : pipe_reg_chain
`default_nettype wire
